// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// feeds the IF/ID register, bubbling it after reset and on branch redirects.
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int unsigned BR_BUBBLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  input  logic [31:0] instr_rdata,
  output logic [63:0] imem_addr,
  output logic [31:0] instruction,
  output logic [63:0] currPC,
  output logic [63:0] pc_plus4,
  output logic        IF_ID_flush,
  output logic        fetch_valid,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_BOOT     = 2'd0,
    S_RUN      = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  localparam logic [63:0] RESET_PC_ALIGNED = {RESET_PC[63:2], 2'b00};
  localparam bit          HAS_BUBBLES      = (BR_BUBBLES != 0);
  localparam logic [2:0]  BCNT_RELOAD      = HAS_BUBBLES ? 3'(BR_BUBBLES - 1) : 3'd0;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [63:0] r_pc;
  logic [63:0] w_pc_nxt;
  logic [2:0]  r_bcnt;
  logic [2:0]  w_bcnt_nxt;
  logic [31:0] r_fetch_count;
  logic [31:0] w_fetch_count_nxt;
  logic        w_flush;
  logic [1:0]  w_unused_br_lsb;

  // Target is always word aligned; the low bits are deliberately dropped.
  assign w_unused_br_lsb = br_target[1:0];

  // State, PC, bubble counter and fetch counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_PC_ALIGNED;
      r_bcnt        <= 3'd0;
      r_fetch_count <= 32'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_bcnt        <= w_bcnt_nxt;
      r_fetch_count <= w_fetch_count_nxt;
    end
  end

  // Next-state logic: a redirect overrides every state and ignores stall.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_bcnt_nxt        = r_bcnt;
    w_fetch_count_nxt = r_fetch_count;
    if (br_taken) begin
      w_pc_nxt    = {br_target[63:2], 2'b00};
      w_state_nxt = HAS_BUBBLES ? S_REDIRECT : S_RUN;
      w_bcnt_nxt  = BCNT_RELOAD;
    end else begin
      case (r_state)
        S_BOOT: begin
          w_state_nxt = S_RUN;
        end
        S_RUN: begin
          if (!stall) begin
            w_pc_nxt          = r_pc + 64'd4;
            w_fetch_count_nxt = r_fetch_count + 32'd1;
          end
        end
        S_REDIRECT: begin
          if (r_bcnt == 3'd0) begin
            w_state_nxt = S_RUN;
          end else begin
            w_bcnt_nxt = r_bcnt - 3'd1;
          end
        end
        default: begin
          w_state_nxt = S_BOOT;
        end
      endcase
    end
  end

  // Squash IF/ID outside RUN, and on the wrong-path fetch of a redirect cycle.
  assign w_flush     = (r_state != S_RUN) | br_taken;

  assign IF_ID_flush = w_flush;
  assign fetch_valid = ~w_flush;
  assign imem_addr   = r_pc;
  assign currPC      = r_pc;
  assign pc_plus4    = r_pc + 64'd4;
  assign instruction = instr_rdata;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: one instance without redirect
// bubbles (table-driven) and one with two bubbles (hand-written sequences).
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic [63:0] br_target;

  logic [31:0] rdata0, rdata2;
  logic [63:0] addr0, addr2, pc0, pc2, p4_0, p4_2;
  logic [31:0] instr0, instr2, cnt0, cnt2;
  logic        flush0, flush2, valid0, valid2;

  int n_pass;
  int n_total;

  typedef struct {
    logic        stall;
    logic        br;
    logic [63:0] tgt;
    logic [63:0] pc;
    logic [63:0] p4;
    logic        flush;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[12];

  // Instruction memory model: data is a simple function of the address.
  function automatic logic [31:0] imem(input logic [63:0] addr);
    return addr[31:0] ^ 32'hDEAD_0000;
  endfunction

  assign rdata0 = imem(addr0);
  assign rdata2 = imem(addr2);

  instr_fetch_unit #(.RESET_PC(64'd200), .BR_BUBBLES(0)) dut0 (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .instr_rdata(rdata0), .imem_addr(addr0),
    .instruction(instr0), .currPC(pc0), .pc_plus4(p4_0),
    .IF_ID_flush(flush0), .fetch_valid(valid0), .fetch_count(cnt0)
  );

  instr_fetch_unit #(.RESET_PC(64'd200), .BR_BUBBLES(2)) dut2 (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .instr_rdata(rdata2), .imem_addr(addr2),
    .instruction(instr2), .currPC(pc2), .pc_plus4(p4_2),
    .IF_ID_flush(flush2), .fetch_valid(valid2), .fetch_count(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs just after the rising edge, then move to the sampling edge.
  task automatic drive(input logic s, input logic b, input logic [63:0] t);
    stall     = s;
    br_taken  = b;
    br_target = t;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    reset     = 1'b1;
    stall     = 1'b0;
    br_taken  = 1'b0;
    br_target = 64'd0;

    // stall, br, target, pc, pc+4, flush, count
    vecs[0]  = '{1'b0, 1'b0, 64'h0,    64'd200,  64'd204,  1'b1, 32'd0}; // boot
    vecs[1]  = '{1'b0, 1'b0, 64'h0,    64'd200,  64'd204,  1'b0, 32'd0};
    vecs[2]  = '{1'b0, 1'b0, 64'h0,    64'd204,  64'd208,  1'b0, 32'd1};
    vecs[3]  = '{1'b1, 1'b0, 64'h0,    64'd208,  64'd212,  1'b0, 32'd2}; // stall
    vecs[4]  = '{1'b1, 1'b0, 64'h0,    64'd208,  64'd212,  1'b0, 32'd2}; // stall
    vecs[5]  = '{1'b0, 1'b0, 64'h0,    64'd208,  64'd212,  1'b0, 32'd2};
    vecs[6]  = '{1'b1, 1'b1, 64'h1003, 64'd212,  64'd216,  1'b1, 32'd3}; // br+stall
    vecs[7]  = '{1'b0, 1'b0, 64'h0,    64'h1000, 64'h1004, 1'b0, 32'd3};
    vecs[8]  = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1004, 64'h1008, 1'b1, 32'd4};
    vecs[9]  = '{1'b0, 1'b0, 64'h0,    64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0, 32'd4};
    vecs[10] = '{1'b0, 1'b0, 64'h0,    64'h0,    64'h4,    1'b0, 32'd5}; // wrapped
    vecs[11] = '{1'b0, 1'b0, 64'h0,    64'h4,    64'h8,    1'b0, 32'd6};

    // Reset state
    adv();
    adv();
    chk("rst_pc",    pc0,           64'd200);
    chk("rst_p4",    p4_0,          64'd204);
    chk("rst_flush", 64'(flush0),   64'd1);
    chk("rst_valid", 64'(valid0),   64'd0);
    chk("rst_cnt",   64'(cnt0),     64'd0);
    reset = 1'b0;

    // Table-driven run on the zero-bubble instance
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].tgt);
      chk($sformatf("v%0d_pc", i),    pc0,          vecs[i].pc);
      chk($sformatf("v%0d_addr", i),  addr0,        vecs[i].pc);
      chk($sformatf("v%0d_p4", i),    p4_0,         vecs[i].p4);
      chk($sformatf("v%0d_flush", i), 64'(flush0),  64'(vecs[i].flush));
      chk($sformatf("v%0d_valid", i), 64'(valid0),  64'(!vecs[i].flush));
      chk($sformatf("v%0d_cnt", i),   64'(cnt0),    64'(vecs[i].cnt));
      chk($sformatf("v%0d_instr", i), 64'(instr0),  64'(imem(vecs[i].pc)));
      adv();
    end

    // Fresh start for the two-bubble instance
    reset = 1'b1;
    drive(1'b0, 1'b0, 64'h0);
    adv();
    reset = 1'b0;

    drive(1'b0, 1'b0, 64'h0);                 // boot
    chk("b_boot_flush", 64'(flush2), 64'd1);
    chk("b_boot_pc",    pc2,         64'd200);
    adv();
    drive(1'b0, 1'b0, 64'h0);                 // run
    chk("b_run_flush",  64'(flush2), 64'd0);
    chk("b_run_pc",     pc2,         64'd200);
    adv();
    drive(1'b0, 1'b1, 64'h400);               // redirect cycle
    chk("b_r1_flush",   64'(flush2), 64'd1);
    chk("b_r1_valid",   64'(valid2), 64'd0);
    chk("b_r1_pc",      pc2,         64'd204);
    adv();
    drive(1'b1, 1'b0, 64'h0);                 // bubble, stall ignored
    chk("b_r2_flush",   64'(flush2), 64'd1);
    chk("b_r2_pc",      pc2,         64'h400);
    adv();
    drive(1'b0, 1'b1, 64'h800);               // re-redirect from bubble
    chk("b_r3_flush",   64'(flush2), 64'd1);
    chk("b_r3_pc",      pc2,         64'h400);
    adv();
    drive(1'b0, 1'b0, 64'h0);
    chk("b_r4_flush",   64'(flush2), 64'd1);
    chk("b_r4_pc",      pc2,         64'h800);
    adv();
    drive(1'b0, 1'b0, 64'h0);
    chk("b_r5_flush",   64'(flush2), 64'd1);
    chk("b_r5_pc",      pc2,         64'h800);
    chk("b_r5_cnt",     64'(cnt2),   64'd1);
    adv();
    drive(1'b0, 1'b0, 64'h0);                 // target fetched
    chk("b_f_flush",    64'(flush2), 64'd0);
    chk("b_f_valid",    64'(valid2), 64'd1);
    chk("b_f_pc",       pc2,         64'h800);
    chk("b_f_instr",    64'(instr2), 64'(imem(64'h800)));
    adv();
    drive(1'b0, 1'b1, 64'h400);               // another redirect
    chk("b_g_pc",       pc2,         64'h804);
    adv();
    drive(1'b0, 1'b0, 64'h0);                 // in REDIRECT
    chk("a_pre_pc",     pc2,         64'h400);
    chk("a_pre_cnt",    64'(cnt2),   64'd2);

    // Asynchronous reset mid-cycle, no clock edge involved
    reset = 1'b1;
    #1;
    chk("a_pc",    pc2,         64'd200);
    chk("a_p4",    p4_2,        64'd204);
    chk("a_flush", 64'(flush2), 64'd1);
    chk("a_valid", 64'(valid2), 64'd0);
    chk("a_cnt",   64'(cnt2),   64'd0);
    adv();
    reset = 1'b0;
    drive(1'b0, 1'b0, 64'h0);
    chk("a_boot_flush", 64'(flush2), 64'd1);
    chk("a_boot_pc",    pc2,         64'd200);
    adv();
    drive(1'b0, 1'b0, 64'h0);
    chk("a_run_flush",  64'(flush2), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
